// File: rtl/uart_rx_deser_pkg.sv
// Shared receiver constants: FSM state encoding, oversample ratio and majority-vote sample points.
package uart_rx_deser_pkg;

    typedef enum logic [2:0] {
        URX_IDLE      = 3'd0,
        URX_START     = 3'd1,
        URX_DATA      = 3'd2,
        URX_STOP      = 3'd3,
        URX_WAIT_HIGH = 3'd4
    } urx_state_e;

    localparam int         URX_OVERSAMPLE = 16;
    localparam logic [3:0] URX_VOTE_FIRST = 4'd7;
    localparam logic [3:0] URX_VOTE_MID   = 4'd8;
    localparam logic [3:0] URX_VOTE_LAST  = 4'd9;
    localparam logic [3:0] URX_SCNT_WRAP  = 4'(URX_OVERSAMPLE - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deser_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks; counter parked at 0 while held.
// Shared with the transmit side, so it knows nothing about frames.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] tcnt_q;
    logic [W-1:0] tcnt_d;

    assign tick_o = ~hold_i & (tcnt_q == W'(DIV - 1));

    always_comb begin
        tcnt_d = tcnt_q + W'(1);
        if (hold_i || restart_i || tick_o) begin
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 receiver: 16x oversampled, 3-sample majority vote per bit, glitch-start rejection,
// separate framing-error pulse. Good bytes appear as a one-cycle rxnew_o with rxdata_o held.
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int CLK_FREQ = 62_500_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       rxnew_o,
    output logic [7:0] rxdata_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int DIV = CLK_FREQ / (BAUD * URX_OVERSAMPLE);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_rx_deser: CLK_FREQ too low for BAUD (DIV < 1)");
        end
    endgenerate

    logic       rx_meta_q, rxs_q, rxs_dly_q;
    urx_state_e state_q;
    logic [3:0] scnt_q;
    logic [2:0] bidx_q;
    logic [1:0] vote_q;
    logic [7:0] shift_q;
    logic [7:0] rxdata_q;
    logic       good_pend_q, rxnew_q;
    logic       err_pend_q, frame_err_q;

    logic in_idle, fall, tick, bit_d, vote_pt, wrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            rxs_dly_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
            rxs_dly_q <= rxs_q;
        end
    end

    assign in_idle = (state_q == URX_IDLE);
    assign fall    = rxs_dly_q & ~rxs_q;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .restart_i (in_idle & fall),
        .hold_i    (in_idle),
        .tick_o    (tick)
    );

    // The third vote is the live sample, so the decision lands on the scnt==9 tick itself.
    assign bit_d   = maj3(vote_q[1], vote_q[0], rxs_q);
    assign vote_pt = tick && (scnt_q == URX_VOTE_LAST);
    assign wrap    = tick && (scnt_q == URX_SCNT_WRAP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= URX_IDLE;
            scnt_q      <= '0;
            bidx_q      <= '0;
            vote_q      <= '0;
            shift_q     <= '0;
            rxdata_q    <= '0;
            good_pend_q <= 1'b0;
            rxnew_q     <= 1'b0;
            err_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            good_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
            rxnew_q     <= good_pend_q;
            frame_err_q <= err_pend_q;

            if (tick) begin
                scnt_q <= scnt_q + 4'd1;
                if (scnt_q == URX_VOTE_FIRST || scnt_q == URX_VOTE_MID) begin
                    vote_q <= {vote_q[0], rxs_q};
                end
            end

            case (state_q)
                URX_IDLE: begin
                    if (fall) begin
                        state_q <= URX_START;
                        scnt_q  <= '0;
                        bidx_q  <= '0;
                    end
                end
                URX_START: begin
                    if (vote_pt && bit_d) begin
                        state_q <= URX_IDLE;
                    end else if (wrap) begin
                        state_q <= URX_DATA;
                    end
                end
                URX_DATA: begin
                    if (vote_pt) begin
                        shift_q <= {bit_d, shift_q[7:1]};
                    end
                    if (wrap) begin
                        bidx_q <= bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
                            state_q <= URX_STOP;
                        end
                    end
                end
                URX_STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is never missed.
                    if (vote_pt) begin
                        if (bit_d) begin
                            rxdata_q    <= shift_q;
                            good_pend_q <= 1'b1;
                            state_q     <= URX_IDLE;
                        end else begin
                            err_pend_q <= 1'b1;
                            state_q    <= URX_WAIT_HIGH;
                        end
                    end
                end
                URX_WAIT_HIGH: begin
                    if (rxs_q) begin
                        state_q <= URX_IDLE;
                    end
                end
                default: state_q <= URX_IDLE;
            endcase
        end
    end

    assign rxnew_o     = rxnew_q;
    assign rxdata_o    = rxdata_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = ~in_idle;

endmodule
